// File: rtl/fetch_unit.sv
// Instruction fetch stage for the pipelined LC-3b datapath: owns the PC, talks to
// instruction memory over read/resp, and presents IR plus decoded mode bits to decode.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic        imem_resp,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        if_valid,
   output logic [15:0] if_ir,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2,
   output logic [3:0]  if_opcode,
   output logic        if_a,
   output logic        if_d,
   output logic        if_r
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   localparam logic [15:0] RST_PC = RESET_PC & 16'hFFFE;

   state_t      state_reg;
   logic [15:0] addr_reg;
   logic [15:0] pc_next_reg;
   logic [15:0] buf_ir_reg;
   logic [15:0] buf_pc_reg;
   logic [15:0] ir_reg;
   logic [15:0] pc_reg;
   logic        valid_reg;
   logic [15:0] target;

   assign target = redirect_pc & 16'hFFFE;

   // Gated by rst_n so the request drops the instant reset asserts.
   assign imem_read    = rst_n && (state_reg != HOLD);
   assign imem_address = addr_reg;

   assign if_valid    = valid_reg;
   assign if_ir       = ir_reg;
   assign if_pc       = pc_reg;
   assign if_pc_plus2 = pc_reg + 16'd2;
   assign if_opcode   = ir_reg[15:12];
   assign if_a        = ir_reg[5];
   assign if_d        = ir_reg[4];
   assign if_r        = ir_reg[11];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         addr_reg    <= RST_PC;
         pc_next_reg <= RST_PC;
         buf_ir_reg  <= 16'h0000;
         buf_pc_reg  <= 16'h0000;
         ir_reg      <= 16'h0000;
         pc_reg      <= 16'h0000;
         valid_reg   <= 1'b0;
      end else begin
         case (state_reg)
            FETCH: begin
               if (imem_resp) begin
                  if (redirect) begin
                     addr_reg  <= target;
                     valid_reg <= 1'b0;
                  end else if (!valid_reg || !stall) begin
                     ir_reg    <= imem_rdata;
                     pc_reg    <= addr_reg;
                     valid_reg <= 1'b1;
                     addr_reg  <= addr_reg + 16'd2;
                  end else begin
                     // Decode is stalled on a live word: park the new one.
                     buf_ir_reg <= imem_rdata;
                     buf_pc_reg <= addr_reg;
                     addr_reg   <= addr_reg + 16'd2;
                     state_reg  <= HOLD;
                  end
               end else if (redirect) begin
                  // Read in flight: address must stay put until it completes.
                  pc_next_reg <= target;
                  valid_reg   <= 1'b0;
                  state_reg   <= DRAIN;
               end else if (valid_reg && !stall) begin
                  valid_reg <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  addr_reg  <= target;
                  valid_reg <= 1'b0;
                  state_reg <= FETCH;
               end else if (!stall) begin
                  ir_reg    <= buf_ir_reg;
                  pc_reg    <= buf_pc_reg;
                  state_reg <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_resp) begin
                  addr_reg  <= redirect ? target : pc_next_reg;
                  state_reg <= FETCH;
               end else if (redirect) begin
                  pc_next_reg <= target;
               end
            end
            default: state_reg <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-exact stimulus against a latency-programmable
// memory model, plus a second instance exercising the wrap-around reset PC.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect;
   logic [15:0] redirect_pc;

   logic        a_read, a_resp, a_valid, a_a, a_d, a_r;
   logic [15:0] a_addr, a_rdata, a_ir, a_pc, a_pc2;
   logic [3:0]  a_op;

   logic        b_read, b_resp, b_valid, b_a, b_d, b_r;
   logic [15:0] b_addr, b_rdata, b_ir, b_pc, b_pc2;
   logic [3:0]  b_op;
   logic        zero_bit = 1'b0;
   logic [15:0] zero_word = 16'h0000;

   logic [15:0] words [16];
   int          lat;
   int          a_cnt, b_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(16'h0000)) dut_a (
      .clk(clk), .rst_n(rst_n), .imem_read(a_read), .imem_address(a_addr),
      .imem_resp(a_resp), .imem_rdata(a_rdata), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .if_valid(a_valid), .if_ir(a_ir), .if_pc(a_pc),
      .if_pc_plus2(a_pc2), .if_opcode(a_op), .if_a(a_a), .if_d(a_d), .if_r(a_r)
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
      .clk(clk), .rst_n(rst_n), .imem_read(b_read), .imem_address(b_addr),
      .imem_resp(b_resp), .imem_rdata(b_rdata), .stall(zero_bit), .redirect(zero_bit),
      .redirect_pc(zero_word), .if_valid(b_valid), .if_ir(b_ir), .if_pc(b_pc),
      .if_pc_plus2(b_pc2), .if_opcode(b_op), .if_a(b_a), .if_d(b_d), .if_r(b_r)
   );

   // Memory model: responds after 'lat' cycles of an asserted read, for one cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_resp <= 1'b0; a_cnt <= 0; a_rdata <= 16'h0000;
      end else if (a_resp) begin
         a_resp <= 1'b0; a_cnt <= 0;
      end else if (a_read) begin
         if (a_cnt == lat - 1) begin
            a_resp <= 1'b1; a_rdata <= words[a_addr[4:1]]; a_cnt <= 0;
         end else begin
            a_cnt <= a_cnt + 1;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_resp <= 1'b0; b_cnt <= 0; b_rdata <= 16'h0000;
      end else if (b_resp) begin
         b_resp <= 1'b0; b_cnt <= 0;
      end else if (b_read) begin
         b_resp <= 1'b1; b_rdata <= words[b_addr[4:1]];
      end
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      words[0]  = 16'h1042; words[1]  = 16'h5A81; words[2]  = 16'h2233; words[3]  = 16'h3344;
      words[4]  = 16'h4455; words[5]  = 16'h5566; words[6]  = 16'h6677; words[7]  = 16'h7788;
      words[8]  = 16'h8899; words[9]  = 16'h99AA; words[10] = 16'hAABB; words[11] = 16'hBBCC;
      words[12] = 16'hCCDD; words[13] = 16'hDDEE; words[14] = 16'hEEFF; words[15] = 16'hF00F;
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; lat = 1;

      step(2);
      check("rst_read",   {15'd0, a_read},  16'h0000);
      check("rst_valid",  {15'd0, a_valid}, 16'h0000);
      check("rst_ir",     a_ir,   16'h0000);
      check("rst_pc",     a_pc,   16'h0000);
      check("rst_addr",   a_addr, 16'h0000);
      check("rst_addr_b", b_addr, 16'hFFFE);
      rst_n = 1'b1;

      // First fetch: response at E1, instruction visible after E2
      step(2);
      check("f0_ir",     a_ir,   16'h1042);
      check("f0_pc",     a_pc,   16'h0000);
      check("f0_op",     {12'd0, a_op}, 16'h0001);
      check("f0_pc2",    a_pc2,  16'h0002);
      check("f0_addr",   a_addr, 16'h0002);
      check("f0_read",   {15'd0, a_read}, 16'h0001);
      check("b_pc",      b_pc,   16'hFFFE);
      check("b_ir",      b_ir,   16'hF00F);
      check("b_pc2",     b_pc2,  16'h0000);
      check("b_addr",    b_addr, 16'h0000);
      step(1);
      check("bubble",    {15'd0, a_valid}, 16'h0000);
      step(1);
      check("f1_ir",     a_ir, 16'h5A81);
      check("f1_pc",     a_pc, 16'h0002);
      check("f1_op",     {12'd0, a_op}, 16'h0005);
      check("f1_adr",    {13'd0, a_a, a_d, a_r}, 16'h0001);

      // Stall for four edges while the word at 0004 returns
      stall = 1'b1;
      step(2);
      check("hold_read", {15'd0, a_read}, 16'h0000);
      check("hold_addr", a_addr, 16'h0006);
      check("hold_ir",   a_ir,   16'h5A81);
      step(2);
      check("hold_ir2",  a_ir,   16'h5A81);
      check("hold_rd2",  {15'd0, a_read}, 16'h0000);
      stall = 1'b0;
      step(1);
      check("unbuf_ir",  a_ir,   16'h2233);
      check("unbuf_pc",  a_pc,   16'h0004);
      check("unbuf_vld", {15'd0, a_valid}, 16'h0001);
      check("unbuf_rd",  {15'd0, a_read}, 16'h0001);
      check("unbuf_adr", a_addr, 16'h0006);
      step(2);
      check("f3_ir",     a_ir, 16'h3344);
      check("f3_pc",     a_pc, 16'h0006);

      // Redirect to 3001 during a 3-cycle read at 0008
      lat = 3;
      step(1);
      redirect = 1'b1; redirect_pc = 16'h3001;
      step(1);
      redirect = 1'b0;
      check("drn_addr",  a_addr, 16'h0008);
      check("drn_vld",   {15'd0, a_valid}, 16'h0000);
      check("drn_read",  {15'd0, a_read}, 16'h0001);
      step(1);
      check("drn_addr2", a_addr, 16'h0008);
      check("drn_vld2",  {15'd0, a_valid}, 16'h0000);
      step(1);
      check("tgt_addr",  a_addr, 16'h3000);
      check("tgt_vld",   {15'd0, a_valid}, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("tgt_wait",  {15'd0, a_valid}, 16'h0000);
      end
      step(1);
      check("tgt_pc",    a_pc, 16'h3000);
      check("tgt_ir",    a_ir, 16'h1042);
      lat = 1;

      // Redirect coincident with a response
      step(1);
      redirect = 1'b1; redirect_pc = 16'h0010;
      step(1);
      redirect = 1'b0;
      check("co_vld",    {15'd0, a_valid}, 16'h0000);
      check("co_addr",   a_addr, 16'h0010);
      step(1);
      check("co_vld2",   {15'd0, a_valid}, 16'h0000);
      step(1);
      check("co_ir",     a_ir, 16'h8899);
      check("co_pc",     a_pc, 16'h0010);

      // Redirect while a word is parked in HOLD (redirect beats stall)
      stall = 1'b1;
      step(2);
      check("hr_read",   {15'd0, a_read}, 16'h0000);
      check("hr_ir",     a_ir, 16'h8899);
      redirect = 1'b1; redirect_pc = 16'h0020;
      step(1);
      redirect = 1'b0; stall = 1'b0;
      check("hr_vld",    {15'd0, a_valid}, 16'h0000);
      check("hr_addr",   a_addr, 16'h0020);
      check("hr_read2",  {15'd0, a_read}, 16'h0001);
      step(1);
      check("hr_vld2",   {15'd0, a_valid}, 16'h0000);
      step(1);
      check("hr_pc",     a_pc, 16'h0020);
      check("hr_ir2",    a_ir, 16'h1042);

      // Reset asserted while draining a redirected 3-cycle read
      lat = 3;
      step(1);
      redirect = 1'b1; redirect_pc = 16'h0040;
      step(1);
      redirect = 1'b0;
      check("rd_addr",   a_addr, 16'h0022);
      check("rd_read",   {15'd0, a_read}, 16'h0001);
      rst_n = 1'b0;
      #1;
      check("ar_read",   {15'd0, a_read},  16'h0000);
      check("ar_vld",    {15'd0, a_valid}, 16'h0000);
      check("ar_addr",   a_addr, 16'h0000);
      step(1);
      rst_n = 1'b1; lat = 1;
      step(2);
      check("ar_pc",     a_pc, 16'h0000);
      check("ar_ir",     a_ir, 16'h1042);
      check("ar_vld2",   {15'd0, a_valid}, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
